// File: rtl/uart_rx_if.sv
// Consumer-side handshake bundle of the UART receiver: holding register,
// status flags and the ready back-pressure.
interface uart_rx_if #(
  parameter int DataBits = 8
) ();
  logic [DataBits-1:0] rx_data_o;
  logic                rx_valid_o;
  logic                rx_ready_i;
  logic                frame_err_o;
  logic                parity_err_o;
  logic                overrun_o;

  modport slave (
    output rx_data_o, rx_valid_o, frame_err_o, parity_err_o, overrun_o,
    input  rx_ready_i
  );

  modport master (
    input  rx_data_o, rx_valid_o, frame_err_o, parity_err_o, overrun_o,
    output rx_ready_i
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: mid-bit sampling of 5-8 bit frames with
// optional parity, delivered through a valid/ready holding register.
module uart_rx #(
  parameter int OverSampleRate = 16,
  parameter int DataBits       = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       baud_tick_i,
  input  logic       rx_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  output logic       rx_busy_o,
  uart_rx_if.slave   rx_bus
);

  localparam int TickW = $clog2(OverSampleRate);
  localparam int BitW  = $clog2(DataBits + 1);
  localparam logic [TickW-1:0] MidTick  = TickW'(OverSampleRate / 2 - 1);
  localparam logic [TickW-1:0] LastTick = TickW'(OverSampleRate - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(DataBits - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e              r_state, w_next_state;
  logic                r_rx_meta, r_rxs;
  logic [TickW-1:0]    r_tick_cnt;
  logic [BitW-1:0]     r_bit_cnt;
  logic [DataBits-1:0] r_shift;
  logic                r_par_en, r_par_odd, r_par_err;
  logic [DataBits-1:0] r_data;
  logic                r_valid, r_frame_err, r_parity_err, r_overrun;

  logic w_at_mid, w_at_end;
  logic w_tick_clr, w_start, w_shift, w_par_sample, w_complete;

  assign w_at_mid = baud_tick_i && (r_tick_cnt == MidTick);
  assign w_at_end = baud_tick_i && (r_tick_cnt == LastTick);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_tick_clr   = 1'b0;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_par_sample = 1'b0;
    w_complete   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tick_clr = 1'b1;
        if (baud_tick_i && !r_rxs) begin
          w_start      = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: if (w_at_mid) begin
        w_tick_clr   = 1'b1;
        w_next_state = r_rxs ? S_IDLE : S_DATA;
      end
      S_DATA: if (w_at_end) begin
        w_tick_clr = 1'b1;
        w_shift    = 1'b1;
        if (r_bit_cnt == LastBit) w_next_state = r_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_at_end) begin
        w_tick_clr   = 1'b1;
        w_par_sample = 1'b1;
        w_next_state = S_STOP;
      end
      S_STOP: if (w_at_end) begin
        w_tick_clr   = 1'b1;
        w_complete   = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
      r_state   <= S_IDLE;
    end else begin
      r_rx_meta <= rx_i;
      r_rxs     <= r_rx_meta;
      r_state   <= w_next_state;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_par_err  <= 1'b0;
    end else begin
      if (w_tick_clr)       r_tick_cnt <= '0;
      else if (baud_tick_i) r_tick_cnt <= r_tick_cnt + TickW'(1);

      if (r_state == S_START) r_bit_cnt <= '0;
      else if (w_shift)       r_bit_cnt <= r_bit_cnt + BitW'(1);

      // LSB arrives first, so each new bit enters at the top and walks down.
      if (w_shift) r_shift <= {r_rxs, r_shift[DataBits-1:1]};

      if (w_start) begin
        r_par_en  <= parity_en_i;
        r_par_odd <= parity_odd_i;
        r_par_err <= 1'b0;
      end else if (w_par_sample) begin
        r_par_err <= ((^r_shift) ^ r_rxs) != r_par_odd;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        // A consumer taking the old byte this very cycle frees the slot.
        if (!r_valid || rx_bus.rx_ready_i) begin
          r_data       <= r_shift;
          r_frame_err  <= !r_rxs;
          r_parity_err <= r_par_en && r_par_err;
          r_valid      <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_bus.rx_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_busy_o           = (r_state != S_IDLE);
  assign rx_bus.rx_data_o    = r_data;
  assign rx_bus.rx_valid_o   = r_valid;
  assign rx_bus.frame_err_o  = r_frame_err;
  assign rx_bus.parity_err_o = r_parity_err;
  assign rx_bus.overrun_o    = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// false-start, back-to-back/overrun and mid-frame reset sequences.
module tb_uart_rx;

  localparam int Osr = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       baud_tick_i = 1'b0;
  logic       rx_i = 1'b1;
  logic       parity_en_i = 1'b0;
  logic       parity_odd_i = 1'b0;
  logic       rx_busy_o;
  logic [1:0] tdiv = 2'd0;

  uart_rx_if #(.DataBits(8)) bus ();

  uart_rx #(.OverSampleRate(Osr), .DataBits(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .baud_tick_i  (baud_tick_i),
    .rx_i         (rx_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .rx_busy_o    (rx_busy_o),
    .rx_bus       (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  // Oversample strobe every 4 clocks.
  always @(posedge clk_i) begin
    tdiv        <= tdiv + 2'd1;
    baud_tick_i <= (tdiv == 2'd3);
  end

  int n_pass = 0;
  int n_total = 0;
  int busy_ticks = 0;
  int ovr_cnt = 0;
  bit busy_seen = 0;

  // A tick seen high at a negedge is consumed by the DUT at the next posedge.
  always @(negedge clk_i) begin
    if (rx_busy_o && baud_tick_i) busy_ticks++;
    if (rx_busy_o) busy_seen = 1;
    if (bus.overrun_o) ovr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic wait_tick();
    do @(negedge clk_i); while (!baud_tick_i);
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (Osr) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pen, input logic podd,
                            input logic pbit, input logic stop, input int idle_bits);
    wait_tick();
    parity_en_i  = pen;
    parity_odd_i = podd;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (pen) send_bit(pbit);
    send_bit(stop);
    rx_i = 1'b1;
    repeat (idle_bits * Osr) wait_tick();
  endtask

  task automatic consume(input string name);
    @(negedge clk_i) bus.rx_ready_i = 1'b1;
    @(negedge clk_i) bus.rx_ready_i = 1'b0;
    check({name, "_valid_clr"}, 32'(bus.rx_valid_o), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
    int         exp_busy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // 8N1: 8 + 9*16 ticks busy; with parity one more bit; the frame-error
    // case adds an 8-tick false start caused by the low stop bit.
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 152};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 168};
    vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 168};
    vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 168};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 160};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 168};
    vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 168};

    bus.rx_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_valid", 32'(bus.rx_valid_o), 32'd0);
    check("rst_data", 32'(bus.rx_data_o), 32'd0);
    check("rst_busy", 32'(rx_busy_o), 32'd0);
    check("rst_flags", {29'd0, bus.frame_err_o, bus.parity_err_o, bus.overrun_o}, 32'd0);
    rst_ni = 1'b1;
    repeat (8) @(negedge clk_i);

    for (int v = 0; v < 7; v++) begin
      busy_ticks = 0;
      send_frame(vecs[v].data, vecs[v].pen, vecs[v].podd, vecs[v].pbit, vecs[v].stop, 2);
      check($sformatf("v%0d_valid", v), 32'(bus.rx_valid_o), 32'd1);
      check($sformatf("v%0d_data", v), 32'(bus.rx_data_o), 32'(vecs[v].exp_data));
      check($sformatf("v%0d_fe", v), 32'(bus.frame_err_o), 32'(vecs[v].exp_fe));
      check($sformatf("v%0d_pe", v), 32'(bus.parity_err_o), 32'(vecs[v].exp_pe));
      check($sformatf("v%0d_busy_ticks", v), 32'(busy_ticks), 32'(vecs[v].exp_busy));
      consume($sformatf("v%0d", v));
    end

    // False start: 5-tick low glitch, rejected at the mid-start sample.
    busy_ticks = 0;
    busy_seen  = 0;
    wait_tick();
    rx_i = 1'b0;
    repeat (5) wait_tick();
    rx_i = 1'b1;
    repeat (32) wait_tick();
    check("fs_busy_pulsed", 32'(busy_seen), 32'd1);
    check("fs_busy_ticks", 32'(busy_ticks), 32'd8);
    check("fs_idle", 32'(rx_busy_o), 32'd0);
    check("fs_no_valid", 32'(bus.rx_valid_o), 32'd0);

    // Back-to-back with no consumer: second frame overruns.
    ovr_cnt = 0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    check("ovr_data", 32'(bus.rx_data_o), 32'h11);
    check("ovr_valid", 32'(bus.rx_valid_o), 32'd1);
    check("ovr_pulses", 32'(ovr_cnt), 32'd1);
    consume("ovr");

    // Back-to-back with ready exactly on the second completion cycle.
    ovr_cnt = 0;
    begin
      bit found;
      found = 0;
      fork
        begin
          send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0);
          send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        end
        begin
          int n;
          n = 0;
          for (int c = 0; c < 5000 && !found; c++) begin
            @(negedge clk_i);
            if (rx_busy_o && baud_tick_i) begin
              n++;
              if (n == 2 * 152) begin
                found = 1;
                bus.rx_ready_i = 1'b1;
                @(negedge clk_i) bus.rx_ready_i = 1'b0;
              end
            end
          end
        end
      join
      check("b2b_ready_hit", 32'(found), 32'd1);
    end
    check("b2b_data", 32'(bus.rx_data_o), 32'h22);
    check("b2b_valid", 32'(bus.rx_valid_o), 32'd1);
    check("b2b_no_ovr", 32'(ovr_cnt), 32'd0);

    // Reset during data bit 4 while an older byte is still held.
    ovr_cnt = 0;
    wait_tick();
    parity_en_i = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b1 : 1'b0);
    rx_i = 1'b1;
    repeat (8) wait_tick();
    check("mr_busy_before", 32'(rx_busy_o), 32'd1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("mr_valid", 32'(bus.rx_valid_o), 32'd0);
    check("mr_data", 32'(bus.rx_data_o), 32'd0);
    check("mr_busy", 32'(rx_busy_o), 32'd0);
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (64) wait_tick();
    check("mr_no_valid_after", 32'(bus.rx_valid_o), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    check("mr_next_valid", 32'(bus.rx_valid_o), 32'd1);
    check("mr_next_data", 32'(bus.rx_data_o), 32'h5A);
    check("mr_next_flags", {30'd0, bus.frame_err_o, bus.parity_err_o}, 32'd0);
    check("mr_no_ovr", 32'(ovr_cnt), 32'd0);
    consume("mr");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
